// File: rtl/xvga_pkg.sv
// xvga_pkg: shared timing constants and pixel type for the XVGA raster generator.
// Default timing is 1024x768 @ 60 Hz with a 65 MHz pixel clock.
// The optional test-pattern source is enabled by defining XVGA_TEST_PATTERN_EN.
package xvga_pkg;

   // Default horizontal timing, in pixels
   localparam int unsigned DEF_H_ACTIVE = 1024;
   localparam int unsigned DEF_H_FP     = 24;
   localparam int unsigned DEF_H_SYNC   = 136;
   localparam int unsigned DEF_H_BP     = 160;

   // Default vertical timing, in lines
   localparam int unsigned DEF_V_ACTIVE = 768;
   localparam int unsigned DEF_V_FP     = 3;
   localparam int unsigned DEF_V_SYNC   = 6;
   localparam int unsigned DEF_V_BP     = 29;

   // Derived totals and sync windows for the default timing
   localparam int unsigned H_TOTAL     = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL     = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int unsigned HSYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int unsigned HSYNC_END   = HSYNC_START + DEF_H_SYNC - 1;
   localparam int unsigned VSYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int unsigned VSYNC_END   = VSYNC_START + DEF_V_SYNC - 1;

   // 24-bit RGB pixel: r=23:16, g=15:8, b=7:0
   typedef logic [23:0] pixel_t;

   // Inclusive unsigned window test used by the sync decodes
   function automatic logic in_window(input logic [31:0] x,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (x >= lo) && (x <= hi);
   endfunction

endpackage

// File: rtl/xvga_timing_test_pattern.sv
// xvga_test_pattern: registered colour-bar test pattern for display bring-up.
// Driven from the next-state counters and blank of xvga_timing so the pixel
// lines up with hcount/vcount/blank with zero latency. Only instantiated when
// XVGA_TEST_PATTERN_EN is defined.
module xvga_test_pattern
   import xvga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
   input  logic        vclock,
   input  logic        reset_n,
   input  logic [10:0] hcount_nxt,
   input  logic [9:0]  vcount_nxt,
   input  logic        blank_nxt,
   output pixel_t      pixel
);

   localparam logic [10:0] H_EDGE = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  V_EDGE = 10'(V_ACTIVE - 1);

   pixel_t     pixel_d;
   pixel_t     pixel_q;
   logic [2:0] bar;
   logic       border;

   // Pick black in blanking, white on the visible border, else one of eight bars
   always_comb begin
      pixel_d = '0;
      bar     = hcount_nxt[9:7];
      border  = (hcount_nxt == 11'd0) || (hcount_nxt == H_EDGE) ||
                (vcount_nxt == 10'd0) || (vcount_nxt == V_EDGE);
      if (blank_nxt) begin
         pixel_d = '0;
      end else if (border) begin
         pixel_d = 24'hFF_FFFF;
      end else begin
         pixel_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      end
   end

   // Pixel register, cleared asynchronously with the rest of the timing state
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         pixel_q <= '0;
      end else begin
         pixel_q <= pixel_d;
      end
   end

   assign pixel = pixel_q;

endmodule

// File: rtl/xvga_timing.sv
// xvga_timing: raster timing generator (hcount/vcount/hsync/vsync/blank,
// frame_start, frame_count). All outputs are registered from next-state values
// so every output refers to the same pixel in the same cycle.
// Optional feature macro: XVGA_TEST_PATTERN_EN adds the pattern_pixel output.
module xvga_timing
   import xvga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic        vclock,
   input  logic        reset_n,
   output logic [10:0] hcount,
   output logic [9:0]  vcount,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
   output logic        frame_start,
   output logic [7:0]  frame_count
`ifdef XVGA_TEST_PATTERN_EN
   ,
   output pixel_t      pattern_pixel
`endif
);

   localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

   // Counter widths are fixed by the port list; reject timings that do not fit
   if ((H_TOT > 2048) || (V_TOT > 1024) || (H_ACTIVE == 0) || (V_ACTIVE == 0) ||
       (H_SYNC == 0) || (V_SYNC == 0)) begin : g_bad_timing
      $error("xvga_timing: timing parameters do not fit the 11-bit/10-bit counters");
   end

   localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOT - 1);
   localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
   localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);

   logic [10:0] hcount_d, hcount_q;
   logic [9:0]  vcount_d, vcount_q;
   logic        hsync_d, hsync_q;
   logic        vsync_d, vsync_q;
   logic        blank_d, blank_q;
   logic        frame_start_d, frame_start_q;
   logic [7:0]  frame_count_d, frame_count_q;
   logic        h_wrap;
   logic        frame_wrap;

   // Next-state counters and the decodes derived from them
   always_comb begin
      h_wrap     = (hcount_q == H_LAST);
      frame_wrap = h_wrap && (vcount_q == V_LAST);

      hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;

      vcount_d = vcount_q;
      if (frame_wrap) begin
         vcount_d = 10'd0;
      end else if (h_wrap) begin
         vcount_d = vcount_q + 10'd1;
      end

      hsync_d = ~in_window(32'(hcount_d), 32'(HS_START), 32'(HS_END));
      vsync_d = ~in_window(32'(vcount_d), 32'(VS_START), 32'(VS_END));
      blank_d = (hcount_d >= H_VIS) || (vcount_d >= V_VIS);

      // (0,0) is only reached again through a frame wrap, so the reset-time
      // (0,0) of the first frame never raises frame_start.
      frame_start_d = frame_wrap;
      frame_count_d = frame_wrap ? frame_count_q + 8'd1 : frame_count_q;
   end

   // Timing state registers; reset returns the raster to pixel (0,0) at once
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         hcount_q      <= 11'd0;
         vcount_q      <= 10'd0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank       = blank_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

`ifdef XVGA_TEST_PATTERN_EN
   xvga_test_pattern #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_pattern (
      .vclock     (vclock),
      .reset_n    (reset_n),
      .hcount_nxt (hcount_d),
      .vcount_nxt (vcount_d),
      .blank_nxt  (blank_d),
      .pixel      (pattern_pixel)
   );
`endif

endmodule

// File: tb/tb_xvga_timing.sv
// tb_xvga_timing: scoreboard bench for xvga_timing. Uses the real horizontal
// timing and a shortened vertical timing so several frames fit in a short run.
module tb_xvga_timing;

   localparam int HA = 1024, HF = 24, HS = 136, HB = 160;
   localparam int VA = 6, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        vclock = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync, vsync, blank, frame_start;
   logic [7:0]  frame_count;
   logic [23:0] pattern_pixel;

   xvga_timing #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .vclock      (vclock),
      .reset_n     (reset_n),
      .hcount      (hcount),
      .vcount      (vcount),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .frame_start (frame_start),
      .frame_count (frame_count)
`ifdef XVGA_TEST_PATTERN_EN
      ,
      .pattern_pixel (pattern_pixel)
`endif
   );

`ifndef XVGA_TEST_PATTERN_EN
   assign pattern_pixel = '0;
`endif

   always #5 vclock = ~vclock;

   typedef struct {
      int h; int v; bit hs; bit vs; bit bl; bit fs; int fc; int px;
   } exp_t;

   exp_t q[$];
   int   t = 0;
   int   total = 0;
   int   bad = 0;

   function automatic exp_t reset_exp();
      exp_t e;
      e.h = 0; e.v = 0; e.hs = 1; e.vs = 1; e.bl = 0; e.fs = 0; e.fc = 0; e.px = 0;
      return e;
   endfunction

   // Expected outputs tt cycles after reset release, from the raster rules
   function automatic exp_t model(int tt);
      exp_t e;
      int   i;
      e.h  = tt % HT;
      e.v  = (tt / HT) % VT;
      e.hs = !(e.h >= HA + HF && e.h <= HA + HF + HS - 1);
      e.vs = !(e.v >= VA + VF && e.v <= VA + VF + VS - 1);
      e.bl = (e.h >= HA) || (e.v >= VA);
      e.fs = (tt > 0) && (tt % FT == 0);
      e.fc = (tt / FT) % 256;
      e.px = 0;
`ifdef XVGA_TEST_PATTERN_EN
      if (e.bl) e.px = 0;
      else if (e.h == 0 || e.h == HA - 1 || e.v == 0 || e.v == VA - 1) e.px = 24'hFFFFFF;
      else begin
         i = (e.h / 128) % 8;
         e.px = (((i & 4) != 0) ? 32'hFF0000 : 0) + (((i & 2) != 0) ? 32'h00FF00 : 0) +
                (((i & 1) != 0) ? 32'h0000FF : 0);
      end
`endif
      return e;
   endfunction

   task automatic check(input exp_t e, input string name);
      bit ok;
      total++;
      ok = (int'(hcount) == e.h) && (int'(vcount) == e.v) && (hsync == e.hs) &&
           (vsync == e.vs) && (blank == e.bl) && (frame_start == e.fs) &&
           (int'(frame_count) == e.fc) && (int'(pattern_pixel) == e.px);
      if (!ok) begin
         bad++;
         $display("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d px=%h want h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d px=%h",
                  name, t, hcount, vcount, hsync, vsync, blank, frame_start, frame_count,
                  pattern_pixel, e.h, e.v, e.hs, e.vs, e.bl, e.fs, e.fc, e.px[23:0]);
         if (bad >= 40) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   endtask

   // Stimulus side: each clock edge advances the reference raster and queues it
   always @(posedge vclock) begin
      if (reset_n) begin
         t = t + 1;
         q.push_back(model(t));
      end else begin
         t = 0;
         q.push_back(reset_exp());
      end
   end

   // Monitor: outputs are valid every cycle; compare on the falling edge
   always @(negedge vclock) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (!reset_n) e = reset_exp();
         check(e, reset_n ? "raster" : "reset_hold");
      end
   end

   initial begin
      int target;
      int n;
      reset_n = 1'b0;
      repeat (10) @(posedge vclock);
      #2 reset_n = 1'b1;

      // Two full frames, then into the third frame at line 3, pixel 500
      target = 2 * FT + 3 * HT + 500;
      n = 0;
      while (t != target && n < 3 * FT) begin
         @(posedge vclock);
         #1;
         n++;
      end
      if (t != target) begin
         total++;
         bad++;
         $display("FAIL reach_target t=%0d want %0d", t, target);
      end

      // Mid-frame asynchronous reset: outputs must clear with no clock edge
      #1 reset_n = 1'b0;
      #1 check(reset_exp(), "async_reset");
      repeat (3) @(posedge vclock);
      #2 reset_n = 1'b1;
      repeat (2 * HT + 50) @(posedge vclock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
